// File: rtl/retire_trace_if.sv
// Retire-side and trace-side signals of retire_trace bundled as one interface.
// The slave modport is the trace unit; the master modport drives retires and consumes records.
interface retire_trace_if;
  logic         trace_en;
  logic         retire_valid_rb1;
  logic [31:0]  retire_pc_rb1;
  logic [4:0]   retire_robid_rb1;
  logic         retire_dst_valid_rb1;
  logic [4:0]   retire_dst_gpr_rb1;
  logic [63:0]  retire_dst_data_rb1;
  logic         retire_nuke_rb1;
  logic         trace_valid;
  logic         trace_ready;
  logic [124:0] trace_rec;
  logic [31:0]  retire_count;
  logic [15:0]  drop_count;
  logic         hang_det;

  modport master (
    output trace_en, retire_valid_rb1, retire_pc_rb1, retire_robid_rb1, retire_dst_valid_rb1,
           retire_dst_gpr_rb1, retire_dst_data_rb1, retire_nuke_rb1, trace_ready,
    input  trace_valid, trace_rec, retire_count, drop_count, hang_det
  );

  modport slave (
    input  trace_en, retire_valid_rb1, retire_pc_rb1, retire_robid_rb1, retire_dst_valid_rb1,
           retire_dst_gpr_rb1, retire_dst_data_rb1, retire_nuke_rb1, trace_ready,
    output trace_valid, trace_rec, retire_count, drop_count, hang_det
  );
endinterface

// File: rtl/retire_trace.sv
// Retirement trace capture: in-order record FIFO with drop accounting, retire counters and a
// no-retire watchdog.
module retire_trace #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned HANG_TIMEOUT = 40
) (
  input  logic         clk,
  input  logic         reset,
  retire_trace_if.slave bus_io
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned RecW = 125;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StHung = 2'd2;

  localparam logic [AW:0] PtrOne   = {{AW{1'b0}}, 1'b1};
  localparam logic [15:0] HangLast = 16'(HANG_TIMEOUT - 1);

  logic [RecW-1:0] mem_q [DEPTH];
  logic [AW:0]     head_q, head_d, tail_q, tail_d;
  logic [15:0]     seq_q, seq_d;
  logic [31:0]     retire_cnt_q, retire_cnt_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;
  logic            lost_pend_q, lost_pend_d;
  logic [1:0]      state_q, state_d;
  logic [15:0]     idle_cnt_q, idle_cnt_d;

  logic            empty, full, retire, push, pop, accept, drop, trace_valid;
  logic [RecW-1:0] rec;

  assign empty  = (head_q == tail_q);
  assign full   = (head_q[AW] != tail_q[AW]) && (head_q[AW-1:0] == tail_q[AW-1:0]);
  assign retire = bus_io.retire_valid_rb1;
  assign push   = retire && bus_io.trace_en;

  // Gated by reset so the output drops in the very cycle reset is asserted.
  assign trace_valid = reset && !empty;
  assign pop         = trace_valid && bus_io.trace_ready;
  assign accept      = push && (!full || pop);
  assign drop        = push && full && !pop;

  assign rec = {seq_q, lost_pend_q, bus_io.retire_nuke_rb1, bus_io.retire_dst_valid_rb1,
                bus_io.retire_dst_gpr_rb1, bus_io.retire_dst_data_rb1,
                bus_io.retire_robid_rb1, bus_io.retire_pc_rb1};

  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    seq_d        = seq_q;
    retire_cnt_d = retire_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    lost_pend_d  = lost_pend_q;
    if (retire) begin
      seq_d        = seq_q + 16'd1;
      retire_cnt_d = retire_cnt_q + 32'd1;
    end
    if (pop) begin
      head_d = head_q + PtrOne;
    end
    if (accept) begin
      tail_d      = tail_q + PtrOne;
      lost_pend_d = 1'b0;
    end
    if (drop) begin
      lost_pend_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    case (state_q)
      StIdle: begin
        if (retire) begin
          state_d    = StRun;
          idle_cnt_d = '0;
        end
      end
      StRun: begin
        if (retire) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == HangLast) begin
          state_d = StHung;
        end else begin
          idle_cnt_d = idle_cnt_q + 16'd1;
        end
      end
      StHung: begin
        if (retire) begin
          state_d    = StRun;
          idle_cnt_d = '0;
        end
      end
      default: begin
        state_d    = StIdle;
        idle_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q       <= '0;
      tail_q       <= '0;
      seq_q        <= '0;
      retire_cnt_q <= '0;
      drop_cnt_q   <= '0;
      lost_pend_q  <= 1'b0;
      state_q      <= StIdle;
      idle_cnt_q   <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      seq_q        <= seq_d;
      retire_cnt_q <= retire_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      lost_pend_q  <= lost_pend_d;
      state_q      <= state_d;
      idle_cnt_q   <= idle_cnt_d;
    end
  end

  // Storage is not reset; occupancy is defined solely by the pointers.
  always_ff @(posedge clk) begin
    if (reset && accept) begin
      mem_q[tail_q[AW-1:0]] <= rec;
    end
  end

  assign bus_io.trace_valid  = trace_valid;
  assign bus_io.trace_rec    = trace_valid ? mem_q[head_q[AW-1:0]] : '0;
  assign bus_io.retire_count = retire_cnt_q;
  assign bus_io.drop_count   = drop_cnt_q;
  assign bus_io.hang_det     = (state_q == StHung);

endmodule

// File: tb/tb_retire_trace.sv
// Directed bench for retire_trace: a table of single-retire vectors plus hand-written sequences
// for overflow, watchdog, disabled capture and reset mid-drain.
module tb_retire_trace;

  logic clk;
  logic reset;
  retire_trace_if bus ();

  retire_trace #(
    .DEPTH        (16),
    .HANG_TIMEOUT (40)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        en;
    logic [31:0] pc;
    logic [4:0]  robid;
    logic        dv;
    logic [4:0]  gpr;
    logic [63:0] data;
    logic        nuke;
    logic        exp_valid;
    logic [15:0] exp_seq;
    logic [31:0] exp_rc;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [124:0] mk_rec(input logic [15:0] seq, input logic lost,
                                          input logic nuke, input logic dv, input logic [4:0] gpr,
                                          input logic [63:0] data, input logic [4:0] robid,
                                          input logic [31:0] pc);
    return {seq, lost, nuke, dv, gpr, data, robid, pc};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [31:0] pc, input logic [4:0] robid,
                       input logic dv, input logic [4:0] gpr, input logic [63:0] data,
                       input logic nuke);
    bus.trace_en             = en;
    bus.retire_valid_rb1     = 1'b1;
    bus.retire_pc_rb1        = pc;
    bus.retire_robid_rb1     = robid;
    bus.retire_dst_valid_rb1 = dv;
    bus.retire_dst_gpr_rb1   = gpr;
    bus.retire_dst_data_rb1  = data;
    bus.retire_nuke_rb1      = nuke;
  endtask

  task automatic idle();
    bus.retire_valid_rb1 = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    reset       = 1'b0;
    bus.trace_ready = 1'b0;
    drive(1'b1, 32'h0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0);
    idle();

    vecs[0] = '{1'b1, 32'h0000_1000, 5'd3, 1'b1, 5'd5, 64'h1234, 1'b0, 1'b1, 16'd0, 32'd1};
    vecs[1] = '{1'b1, 32'h0000_2004, 5'd31, 1'b0, 5'd0, 64'h0, 1'b1, 1'b1, 16'd1, 32'd2};
    vecs[2] = '{1'b1, 32'hFFFF_FFFC, 5'd0, 1'b1, 5'd31, 64'hDEAD_BEEF_CAFE_F00D, 1'b0,
                1'b1, 16'd2, 32'd3};
    vecs[3] = '{1'b0, 32'h0000_3000, 5'd9, 1'b1, 5'd2, 64'h55, 1'b0, 1'b0, 16'd0, 32'd4};
    vecs[4] = '{1'b1, 32'h0000_3004, 5'd7, 1'b1, 5'd1, 64'h1, 1'b0, 1'b1, 16'd4, 32'd5};

    step();
    step();
    reset = 1'b1;
    check("rst_valid", 128'(bus.trace_valid), 128'd0);
    check("rst_rec", 128'(bus.trace_rec), 128'd0);
    check("rst_rc", 128'(bus.retire_count), 128'd0);
    check("rst_drop", 128'(bus.drop_count), 128'd0);
    check("rst_hang", 128'(bus.hang_det), 128'd0);

    // Table: one retire, record visible one cycle later, popped the cycle after.
    bus.trace_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(vecs[i].en, vecs[i].pc, vecs[i].robid, vecs[i].dv, vecs[i].gpr, vecs[i].data,
            vecs[i].nuke);
      step();
      idle();
      check($sformatf("vec%0d_valid", i), 128'(bus.trace_valid), 128'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_rec", i), 128'(bus.trace_rec),
              128'(mk_rec(vecs[i].exp_seq, 1'b0, vecs[i].nuke, vecs[i].dv, vecs[i].gpr,
                          vecs[i].data, vecs[i].robid, vecs[i].pc)));
      end
      check($sformatf("vec%0d_rc", i), 128'(bus.retire_count), 128'(vecs[i].exp_rc));
      step();
      check($sformatf("vec%0d_popped", i), 128'(bus.trace_valid), 128'd0);
    end
    check("tbl_drop", 128'(bus.drop_count), 128'd0);

    // Overflow: 18 retires into a stalled 16-deep buffer, then retire+pop while full.
    do_reset();
    bus.trace_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      drive(1'b1, 32'h100 + 32'(i * 4), 5'(i), 1'b1, 5'd4, 64'(i), 1'b0);
      step();
    end
    drive(1'b1, 32'h0000_8888, 5'd18, 1'b0, 5'd0, 64'h0, 1'b0);
    bus.trace_ready = 1'b1;
    check("ovf_drop", 128'(bus.drop_count), 128'd2);
    check("ovf_valid", 128'(bus.trace_valid), 128'd1);
    check("ovf_head", 128'(bus.trace_rec),
          128'(mk_rec(16'd0, 1'b0, 1'b0, 1'b1, 5'd4, 64'd0, 5'd0, 32'h100)));
    step();
    idle();
    for (int k = 1; k <= 16; k++) begin
      check($sformatf("drain%0d_valid", k), 128'(bus.trace_valid), 128'd1);
      check($sformatf("drain%0d_seq", k), 128'(bus.trace_rec[124:109]),
            128'(k < 16 ? k : 18));
      check($sformatf("drain%0d_lost", k), 128'(bus.trace_rec[108]), 128'(k == 16));
      step();
    end
    check("drain_empty", 128'(bus.trace_valid), 128'd0);
    check("drain_drop", 128'(bus.drop_count), 128'd2);
    check("drain_rc", 128'(bus.retire_count), 128'd19);

    // Stall holds the head record stable.
    bus.trace_ready = 1'b0;
    drive(1'b1, 32'h0000_4000, 5'd1, 1'b0, 5'd0, 64'h0, 1'b0);
    step();
    idle();
    step();
    step();
    check("stall_rec", 128'(bus.trace_rec),
          128'(mk_rec(16'd19, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 5'd1, 32'h0000_4000)));

    // Watchdog, with capture disabled.
    do_reset();
    bus.trace_ready = 1'b1;
    for (int k = 0; k < 50; k++) step();
    check("nohang_idle", 128'(bus.hang_det), 128'd0);
    drive(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0);
    step();
    idle();
    check("wd_after_retire", 128'(bus.hang_det), 128'd0);
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k >= 38) check($sformatf("wd_k%0d", k), 128'(bus.hang_det), 128'(k == 40));
    end
    step();
    step();
    check("wd_sticky", 128'(bus.hang_det), 128'd1);
    drive(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0);
    step();
    idle();
    check("wd_clear", 128'(bus.hang_det), 128'd0);

    // Capture disabled: counted, never buffered, seq still advances.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 32'h500 + 32'(i), 5'd2, 1'b0, 5'd0, 64'h0, 1'b0);
      step();
      check($sformatf("dis%0d_valid", i), 128'(bus.trace_valid), 128'd0);
    end
    check("dis_rc", 128'(bus.retire_count), 128'd5);
    check("dis_drop", 128'(bus.drop_count), 128'd0);
    drive(1'b1, 32'h0000_0600, 5'd6, 1'b0, 5'd0, 64'h0, 1'b0);
    step();
    idle();
    check("dis_next_seq", 128'(bus.trace_rec[124:109]), 128'd5);

    // Reset while 3 records are stalled; retire during reset is ignored.
    do_reset();
    bus.trace_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h700 + 32'(i), 5'd0, 1'b0, 5'd0, 64'h0, 1'b0);
      step();
    end
    check("mid_valid", 128'(bus.trace_valid), 128'd1);
    reset = 1'b0;
    #1;
    check("in_rst_valid", 128'(bus.trace_valid), 128'd0);
    step();
    reset = 1'b1;
    idle();
    check("mid_rst_valid", 128'(bus.trace_valid), 128'd0);
    check("mid_rst_rec", 128'(bus.trace_rec), 128'd0);
    check("mid_rst_rc", 128'(bus.retire_count), 128'd0);
    check("mid_rst_drop", 128'(bus.drop_count), 128'd0);
    for (int k = 0; k < 45; k++) step();
    check("mid_rst_idle", 128'(bus.hang_det), 128'd0);
    drive(1'b1, 32'h0000_0900, 5'd9, 1'b0, 5'd0, 64'h0, 1'b0);
    step();
    idle();
    check("mid_rst_seq", 128'(bus.trace_rec[124:108]), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
